pipe_stage_skid: RTL
====================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised inter-stage pipeline register, successor to the fixed-field EX/MEM latch.
//  Carries NUM_FIELDS x FIELD_W payload fields plus an exception tag through a 2-entry skid buffer.
//  Uses valid/ready handshake, synchronous flush and an optional exception fence.
//  Drops in between any two stages (ID/EX, EX/MEM, MEM/WB). Stalls propagate without a combinational ready path.
// PARAMETERS
//  NUM_FIELDS  7   number of payload fields; field 0 is the instruction word (IR)
//  FIELD_W     32  width of each payload field
//  EXC_W       5   exception code width; 0 = no exception
//  EXC_FENCE   1   1: after accepting a beat with nonzero exc, block input until flush
// PORTS
//  clk        in   1                   clock, rising edge
//  reset      in   1                   synchronous, active-high
//  flush      in   1                   synchronous kill of all held and incoming beats
//  in_valid   in   1                   upstream beat valid
//  in_ready   out  1                   stage can accept; function of internal registers only
//  in_data    in   NUM_FIELDS*FIELD_W  payload; field k = bits [k*FIELD_W +: FIELD_W]
//  in_exc     in   EXC_W               exception code of incoming beat
//  in_bd      in   1                   incoming instruction is in a branch delay slot
//  out_valid  out  1                   downstream beat valid
//  out_ready  in   1                   downstream accepts
//  out_data   out  NUM_FIELDS*FIELD_W  payload of head entry
//  out_exc    out  EXC_W               exception code of head entry
//  out_bd     out  1                   delay-slot flag of head entry
//  occupancy  out  2                   entries held: 0, 1 or 2
// BEHAVIOUR
//  Transfer rules
//  - push = in_valid & in_ready & ~flush
//  - pop  = out_valid & out_ready
//  - All state updates occur on the rising edge of clk.
//  Reset (reset=1)
//  - out_valid=0, out_data=0 (all fields), out_exc=0, out_bd=0, occupancy=0, fence cleared.
//  - in_ready=1 from the first cycle after reset.
//  - Reset overrides flush and any handshake in the same cycle.
//  Storage
//  - main entry drives the out_* ports; skid entry holds the overflow beat. Order is FIFO.
//  States and transitions
//  - EMPTY: push -> ONE, beat loaded into main.
//  - ONE:   push&~pop -> TWO (beat into skid).
//           pop&~push -> EMPTY.
//           push&pop  -> ONE (new beat into main).
//  - TWO:   pop -> ONE (skid moves to main). push cannot occur.
//  Ready
//  - in_ready = (state != TWO) & ~fence.
//  - No combinational path from out_ready or flush to in_ready.
//  Latency and throughput
//  - Latency: beat pushed in cycle N is visible on out_* in cycle N+1 when the stage was EMPTY,
//    or when it was ONE with a pop in cycle N.
//  - Throughput: 1 beat/cycle while out_ready=1.
//  Output stability
//  - While out_valid=1 and out_ready=0, out_data, out_exc and out_bd hold stable.
//  - While out_valid=0, out_data, out_exc and out_bd are all zero (bubble; IR=0 is NOP).
//  Flush (flush=1, reset=0)
//  - Next cycle: state EMPTY, all outputs zero, fence cleared.
//  - A beat presented in the flush cycle is discarded even if in_ready=1.
//  - A pop in the same cycle still completes downstream; the beat is consumed.
//  Exception fence (EXC_FENCE=1)
//  - A push with in_exc!=0 sets fence on that edge; in_ready=0 from the next cycle.
//  - The held entries still drain normally.
//  - Only flush or reset clears the fence.
//  - EXC_FENCE=0: in_exc is carried as plain payload.
//  Width rules
//  - Payload is passed bit-exact; no arithmetic is performed.
//  - occupancy is never 3.
// TESTING
//  - Reset: reset=1 for 2 cycles with in_valid=1, in_data=all 1s.
//    -> out_valid=0, out_data=0, occupancy=0; in_ready=1 on the cycle after reset drops.
//  - Streaming: out_ready=1; push IR=0x8C010004, 0x00221820, 0x10000003 on consecutive cycles.
//    -> each appears one cycle later in order; occupancy stays 1; in_ready stays 1.
//  - Backpressure: out_ready=0; push A=0x11111111 then B=0x22222222.
//    -> occupancy=2, in_ready=0, out_data holds A.
//    -> raise out_ready: A, then B on the next cycle, then out_valid=0 and in_ready=1.
//  - Flush: stage holds two entries; assert flush with in_valid=1, in_data=0x33333333.
//    -> next cycle out_valid=0, out_data=0, occupancy=0; 0x33333333 never appears at output.
//  - Exception fence: push beat with in_exc=5'd12 (Ov) and in_bd=1, then in_valid held 1.
//    -> out_exc=12, out_bd=1; in_ready=0 thereafter; no further push until flush.
//    -> one flush cycle later in_ready=1.
//  - Simultaneous push and pop in state ONE with out_ready=1.
//    -> occupancy stays 1; out_data shows the new beat next cycle; no beat lost or duplicated.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: parametrised 2-entry skid pipeline register with flush and exception fence
module pipe_stage_skid #(
  parameter int NUM_FIELDS = 7,
  parameter int FIELD_W    = 32,
  parameter int EXC_W      = 5,
  parameter bit EXC_FENCE  = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_FIELDS*FIELD_W-1:0] in_data,
  input  logic [EXC_W-1:0]              in_exc,
  input  logic                          in_bd,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_FIELDS*FIELD_W-1:0] out_data,
  output logic [EXC_W-1:0]              out_exc,
  output logic                          out_bd,
  output logic [1:0]                    occupancy
);
  localparam int DW = NUM_FIELDS*FIELD_W;
  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_t;
  state_t          r_state, w_next;
  logic [DW-1:0]   r_main_data, r_skid_data;
  logic [EXC_W-1:0] r_main_exc, r_skid_exc;
  logic            r_main_bd, r_skid_bd, r_fence;
  logic            w_push, w_pop;
  assign in_ready  = (r_state != S_TWO) & ~r_fence;
  assign out_valid = r_state != S_EMPTY;
  assign occupancy = r_state;
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready;
  // stale main contents are masked so bubbles always read as zero (NOP)
  assign out_data  = out_valid ? r_main_data : '0;
  assign out_exc   = out_valid ? r_main_exc : '0;
  assign out_bd    = out_valid & r_main_bd;
  always_ff @(posedge clk)
    r_state <= reset ? S_EMPTY : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_EMPTY: w_next = w_push ? S_ONE : S_EMPTY;
      S_ONE:   w_next = (w_push & ~w_pop) ? S_TWO : (w_pop & ~w_push) ? S_EMPTY : S_ONE;
      S_TWO:   w_next = w_pop ? S_ONE : S_TWO;
      default: w_next = S_EMPTY;
    endcase
    if (flush) w_next = S_EMPTY;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_data <= '0;
      r_main_exc  <= '0;
      r_main_bd   <= 1'b0;
      r_skid_data <= '0;
      r_skid_exc  <= '0;
      r_skid_bd   <= 1'b0;
      r_fence     <= 1'b0;
    end else if (flush) begin
      r_fence <= 1'b0;
    end else begin
      if (w_push && (r_state == S_EMPTY || w_pop)) begin
        r_main_data <= in_data;
        r_main_exc  <= in_exc;
        r_main_bd   <= in_bd;
      end else if (w_pop && r_state == S_TWO) begin
        r_main_data <= r_skid_data;
        r_main_exc  <= r_skid_exc;
        r_main_bd   <= r_skid_bd;
      end
      if (w_push && r_state == S_ONE && !w_pop) begin
        r_skid_data <= in_data;
        r_skid_exc  <= in_exc;
        r_skid_bd   <= in_bd;
      end
      if (EXC_FENCE && w_push && in_exc != '0) r_fence <= 1'b1;
    end
  end
endmodule
